// File: rtl/acl_pkg.sv
// Shared types and constants for the accelerometer event reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package acl_pkg;

  // FSM encoding for the reader.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } acl_state_t;

  // Position of the "event pending" flag inside the controller's event word.
  localparam int ACL_EVT_BIT = 0;

  // Number of BCD digits in the event counter.
  localparam int BCD_DIGITS = 4;

  // Single BCD digit increment; 9 rolls over to 0 (the caller handles carry).
  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with ripple carry between digits; 9999 wraps to 0000.
// Latency: value updates on the clock edge where inc is sampled high.
// Backpressure: none; every inc pulse is counted.
module bcd_counter4
  import acl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] value
);

  logic [4*BCD_DIGITS-1:0] cnt_q;
  logic [4*BCD_DIGITS-1:0] cnt_nxt;
  logic                    carry;

  // Next value: bump digit 0, propagate carry upward while digits roll 9->0.
  always_comb begin
    cnt_nxt = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        cnt_nxt[4*i +: 4] = bcd_digit_inc(cnt_q[4*i +: 4]);
        carry             = (cnt_q[4*i +: 4] == 4'd9);
      end
    end
  end

  // Counter register; only advances on inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_nxt;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/acl_event_reader.sv
// Consumes accelerometer threshold events: ack handshake, BCD event count, "TAP" display hold.
// Latency: ack/new_event/count one cycle after the flag is sampled in IDLE; HOLD lasts HOLDOFF_CYCLES (min 1).
// Backpressure: events are not accepted in ACK or HOLD; producer keeps the flag high until acked.
//   Optional ack timeout: define ACL_READER_ACK_TIMEOUT_EN.
module acl_event_reader
  import acl_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 5000000,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] acl_word,
  output logic        has_been_read,
  output logic        new_event,
  output logic [15:0] event_count,
  output logic        show_msg,
  output logic        ack_err
);

  // Holdoff counter sized for 0..HOLDOFF_CYCLES-1; zero cycles still yields one HOLD cycle.
  localparam int              HOLD_MAX  = (HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES : 1;
  localparam int              HW        = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]   HOLD_LAST = (HOLDOFF_CYCLES > 0) ? HW'(HOLDOFF_CYCLES - 1) : '0;

  acl_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic          evt;
  logic          accept;
  logic          ack_expire;
  logic          unused_word_bits;

  assign evt              = acl_word[ACL_EVT_BIT];
  assign unused_word_bits = ^acl_word[15:1];

  // The counter bumps on the same edge that moves IDLE->ACK, so it lines up with new_event.
  assign accept = (state == IDLE) && evt;

`ifdef ACL_READER_ACK_TIMEOUT_EN
  localparam int TMAX = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT : 1;
  localparam int TW   = $clog2(TMAX + 1);

  logic [TW-1:0] ack_cnt;

  // ack_cnt holds the number of ACK cycles already completed; expire on the last allowed one.
  assign ack_expire = ((int'(ack_cnt) + 1) >= ACK_TIMEOUT);
`else
  localparam int UNUSED_ACK_TIMEOUT = ACK_TIMEOUT;

  assign ack_expire = 1'b0;
  assign ack_err    = 1'b0;
`endif

  bcd_counter4 u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .value (event_count)
  );

  // Reader FSM with all handshake/display outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      has_been_read <= 1'b0;
      new_event     <= 1'b0;
      show_msg      <= 1'b0;
      hold_cnt      <= '0;
`ifdef ACL_READER_ACK_TIMEOUT_EN
      ack_cnt       <= '0;
      ack_err       <= 1'b0;
`endif
    end else begin
      new_event <= 1'b0;
      case (state)
        IDLE: begin
          if (evt) begin
            state         <= ACK;
            has_been_read <= 1'b1;
            new_event     <= 1'b1;
`ifdef ACL_READER_ACK_TIMEOUT_EN
            ack_cnt       <= '0;
`endif
          end
        end
        ACK: begin
          if (!evt) begin
            state         <= HOLD;
            has_been_read <= 1'b0;
            show_msg      <= 1'b1;
            hold_cnt      <= '0;
          end else if (ack_expire) begin
            // Producer never released the flag: give up, flag it, still show the event.
            state         <= HOLD;
            has_been_read <= 1'b0;
            show_msg      <= 1'b1;
            hold_cnt      <= '0;
`ifdef ACL_READER_ACK_TIMEOUT_EN
            ack_err       <= 1'b1;
`endif
          end else begin
`ifdef ACL_READER_ACK_TIMEOUT_EN
            ack_cnt <= ack_cnt + 1'b1;
`endif
          end
        end
        HOLD: begin
          // Flag is deliberately ignored here; the next event is taken in IDLE.
          if (hold_cnt == HOLD_LAST) begin
            state    <= IDLE;
            show_msg <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          has_been_read <= 1'b0;
          show_msg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acl_event_reader.sv
// Directed bench for acl_event_reader with an event-count scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected counts come from a decimal model converted to BCD.
module tb_acl_event_reader;

  localparam int HOLD_N = 8;
  localparam int TO_N   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] acl_word;
  logic        has_been_read;
  logic        new_event;
  logic [15:0] event_count;
  logic        show_msg;
  logic        ack_err;

  int          checks    = 0;
  int          failures  = 0;
  int          model_cnt = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  acl_event_reader #(
    .HOLDOFF_CYCLES (HOLD_N),
    .ACK_TIMEOUT    (TO_N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .acl_word      (acl_word),
    .has_been_read (has_been_read),
    .new_event     (new_event),
    .event_count   (event_count),
    .show_msg      (show_msg),
    .ack_err       (ack_err)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_event();
    model_cnt = (model_cnt + 1) % 10000;
    sb_q.push_back(to_bcd(model_cnt));
  endtask

  task automatic pop_event(input string tag);
    logic [15:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=event expected=nothing queued", tag);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, event_count, exp);
    end
  endtask

  // Counts show_msg-high samples starting at the current one, bounded.
  task automatic wait_hold_end(input string tag, input int exp_len);
    int n;
    n = 0;
    while (show_msg === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk(tag, 16'(n), 16'(exp_len));
  endtask

  // One full event from IDLE: raise flag, observe accept, drop flag, wait out HOLD.
  task automatic do_event(input string tag);
    acl_word = 16'h0001;
    push_event();
    step();
    chk({tag, "_ne"}, 16'(new_event), 16'd1);
    pop_event({tag, "_cnt"});
    acl_word = 16'h0000;
    step();
    wait_hold_end({tag, "_hold"}, HOLD_N);
  endtask

  initial begin
    int stray;
    int low;

    // Reset held for two cycles with the flag already up.
    rst      = 1'b1;
    acl_word = 16'h0001;
    step();
    chk("rst_hbr", 16'(has_been_read), 16'd0);
    chk("rst_ne", 16'(new_event), 16'd0);
    chk("rst_cnt", event_count, 16'h0000);
    chk("rst_msg", 16'(show_msg), 16'd0);
    chk("rst_err", 16'(ack_err), 16'd0);
    step();
    chk("rst_hbr2", 16'(has_been_read), 16'd0);
    chk("rst_cnt2", event_count, 16'h0000);

    // Release: the pending flag is accepted on the first edge.
    push_event();
    rst = 1'b0;
    step();
    chk("rel_hbr", 16'(has_been_read), 16'd1);
    chk("rel_ne", 16'(new_event), 16'd1);
    pop_event("rel_cnt");
    acl_word = 16'h0000;
    step();
    chk("rel_msg", 16'(show_msg), 16'd1);
    wait_hold_end("rel_hold", HOLD_N);

    // Basic handshake: flag cleared one cycle after ack rises.
    acl_word = 16'h0001;
    push_event();
    step();
    chk("b_hbr", 16'(has_been_read), 16'd1);
    chk("b_ne", 16'(new_event), 16'd1);
    pop_event("b_cnt");
    acl_word = 16'h0000;
    step();
    chk("b_hbr_len", 16'(has_been_read), 16'd0);
    chk("b_ne_single", 16'(new_event), 16'd0);
    chk("b_msg", 16'(show_msg), 16'd1);
    wait_hold_end("b_hold", HOLD_N);
    chk("b_idle_hbr", 16'(has_been_read), 16'd0);

    // Flag raised again and held through HOLD: no ack until HOLD ends.
    acl_word = 16'h0001;
    push_event();
    step();
    chk("h_hbr", 16'(has_been_read), 16'd1);
    pop_event("h_cnt");
    acl_word = 16'h0000;
    step();
    chk("h_msg", 16'(show_msg), 16'd1);
    acl_word = 16'h0001;
    stray = 0;
    low   = 0;
    while (show_msg === 1'b1 && low < 200) begin
      low++;
      if (has_been_read !== 1'b0 || new_event !== 1'b0) stray++;
      step();
    end
    chk("h_hold_len", 16'(low), 16'(HOLD_N));
    chk("h_no_ack", 16'(stray), 16'd0);
    chk("h_gap_hbr", 16'(has_been_read), 16'd0);
    push_event();
    step();
    chk("h_reack_hbr", 16'(has_been_read), 16'd1);
    chk("h_reack_ne", 16'(new_event), 16'd1);
    pop_event("h_reack_cnt");
    step();
    chk("h_ack_stay", 16'(has_been_read), 16'd1);
    chk("h_ack_ne0", 16'(new_event), 16'd0);
    chk("h_ack_cnt", event_count, to_bcd(model_cnt));
    step();
    chk("h_ack_stay2", 16'(has_been_read), 16'd1);
    acl_word = 16'h0000;
    step();
    chk("h_msg2", 16'(show_msg), 16'd1);
    wait_hold_end("h_hold2", HOLD_N);

    // BCD carries through real events: 0009->0010 and 0099->0100.
    while (model_cnt < 100) begin
      do_event(model_cnt == 9 ? "bcd_0010" : (model_cnt == 99 ? "bcd_0100" : "bcd_run"));
    end

    // Preload 9999 and check the wrap.
    force dut.u_cnt.cnt_q = 16'h9999;
    #1;
    release dut.u_cnt.cnt_q;
    chk("bcd_preload", event_count, 16'h9999);
    model_cnt = 9999;
    do_event("bcd_wrap");
    do_event("bcd_after_wrap");

`ifdef ACL_READER_ACK_TIMEOUT_EN
    // Flag never released: abort after TO_N ack cycles, count once.
    acl_word = 16'h0001;
    push_event();
    step();
    chk("to_hbr1", 16'(has_been_read), 16'd1);
    pop_event("to_cnt");
    for (int i = 2; i <= TO_N; i++) begin
      step();
      chk("to_hbr_run", 16'(has_been_read), 16'd1);
    end
    step();
    chk("to_hbr_drop", 16'(has_been_read), 16'd0);
    chk("to_msg", 16'(show_msg), 16'd1);
    chk("to_err", 16'(ack_err), 16'd1);
    chk("to_cnt_once", event_count, to_bcd(model_cnt));
    wait_hold_end("to_hold", HOLD_N);
    push_event();
    step();
    chk("to_reack_ne", 16'(new_event), 16'd1);
    pop_event("to_reack_cnt");
    acl_word = 16'h0000;
    step();
    wait_hold_end("to_hold2", HOLD_N);
    chk("to_err_sticky", 16'(ack_err), 16'd1);
`else
    // No timeout: ack is held as long as the flag is.
    acl_word = 16'h0001;
    push_event();
    step();
    pop_event("nt_cnt");
    low = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (has_been_read !== 1'b1) low++;
    end
    chk("nt_hbr_held", 16'(low), 16'd0);
    chk("nt_err", 16'(ack_err), 16'd0);
    chk("nt_msg", 16'(show_msg), 16'd0);
    chk("nt_cnt_once", event_count, to_bcd(model_cnt));
    acl_word = 16'h0000;
    step();
    wait_hold_end("nt_hold", HOLD_N);
`endif

    // Reset during ACK, then re-acceptance of the still-pending flag.
    acl_word = 16'h0001;
    push_event();
    step();
    chk("mr_hbr", 16'(has_been_read), 16'd1);
    pop_event("mr_cnt_pre");
    rst = 1'b1;
    step();
    chk("mr_hbr_drop", 16'(has_been_read), 16'd0);
    chk("mr_cnt_clr", event_count, 16'h0000);
    chk("mr_msg", 16'(show_msg), 16'd0);
    chk("mr_err", 16'(ack_err), 16'd0);
    model_cnt = 0;
    sb_q.delete();
    push_event();
    rst = 1'b0;
    step();
    chk("mr_reack_hbr", 16'(has_been_read), 16'd1);
    chk("mr_reack_ne", 16'(new_event), 16'd1);
    pop_event("mr_reack_cnt");
    acl_word = 16'h0000;
    step();
    wait_hold_end("mr_hold", HOLD_N);
    chk("mr_sb_empty", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
